counter_run_ctrl: RTL

- Sequencing controller for the lab's ripple-style 4-bit binary counter.
- Accepts a run command (terminal value plus repeat count) over a valid/ready handshake, then steps an internal WIDTH-bit count from 0 to the terminal value, wrapping for the requested number of passes.
- Supports pause and abort, and reports per-pass wrap and end-of-run done pulses.
- Sits between a command source (testbench or top-level FSM) and display/LED logic that consumes `count`.

---
 rtl/counter_run_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/counter_run_ctrl.sv
// Run-command sequencer for a WIDTH-bit counter: accepts limit/repeat, counts passes, supports pause/abort.
// Optional down-count mode (cmd_down port) is enabled by defining CNT_CTRL_DOWN_EN.
module counter_run_ctrl #(
  parameter int WIDTH = 4,
  parameter int RPT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic [RPT_W-1:0] cmd_repeat,
`ifdef CNT_CTRL_DOWN_EN
  input  logic             cmd_down,
`endif
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic [RPT_W-1:0] pass_cnt,
  output logic             busy,
  output logic             wrap,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [RPT_W-1:0] pass_q, pass_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;

  logic [WIDTH-1:0] end_val, step_val, reload_val, start_val;
  logic             at_end;

`ifdef CNT_CTRL_DOWN_EN
  logic down_q;

  always_ff @(posedge clk) begin
    if (rst)                              down_q <= 1'b0;
    else if (state_q == S_IDLE && cmd_valid) down_q <= cmd_down;
  end

  assign end_val    = down_q ? '0 : limit_q;
  assign step_val   = down_q ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
  assign reload_val = down_q ? limit_q : '0;
  assign start_val  = cmd_down ? cmd_limit : '0;
`else
  assign end_val    = limit_q;
  assign step_val   = count_q + WIDTH'(1);
  assign reload_val = '0;
  assign start_val  = '0;
`endif

  // step_val is only used when count has not reached end_val, so it never wraps arithmetically
  assign at_end = (count_q == end_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      pass_q  <= '0;
      limit_q <= '0;
      rpt_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pass_q  <= pass_d;
      limit_q <= limit_d;
      rpt_q   <= rpt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pass_d  = pass_q;
    limit_d = limit_q;
    rpt_d   = rpt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          limit_d = cmd_limit;
          rpt_d   = cmd_repeat;
          count_d = start_val;
          pass_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          count_d = '0;
          pass_d  = '0;
        end else if (pause) begin
          state_d = S_HOLD;
        end else if (at_end) begin
          if (pass_q == rpt_q) begin
            state_d = S_DONE;
          end else begin
            count_d = reload_val;
            pass_d  = pass_q + RPT_W'(1);
          end
        end else begin
          count_d = step_val;
        end
      end
      S_HOLD: begin
        if (abort) begin
          state_d = S_IDLE;
          count_d = '0;
          pass_d  = '0;
        end else if (!pause) begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN) || (state_q == S_HOLD);
  assign done      = (state_q == S_DONE);
  assign wrap      = (state_q == S_RUN) && at_end && !pause && !abort;
  assign count     = count_q;
  assign pass_cnt  = pass_q;

endmodule
